// File: rtl/reg_port_arbiter_pkg.sv
// Shared types for reg_port_arbiter: requester owner, FSM state, access record.
// Optional ARB_RR_EN selects round-robin arbitration in the top module.
package reg_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 7;
  localparam int unsigned ARB_DATA_W = 8;
  localparam logic [ARB_ADDR_W-1:0] RO_BASE_DEF = 7'h60;

  typedef enum logic {OWN_SPI, OWN_INT} owner_e;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_e;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } acc_t;

endpackage

// File: rtl/reg_port_arbiter_if.sv
// Request/response bundle between the SPI front end, the internal requester,
// the register file and reg_port_arbiter (slave side = arbiter).
interface reg_port_arbiter_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
);
  logic              spi_req;
  logic              spi_is_write;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_wdata;
  logic [DATA_W-1:0] spi_rdata;
  logic              spi_rvalid;
  logic              int_req;
  logic              int_we;
  logic [ADDR_W-1:0] int_addr;
  logic [DATA_W-1:0] int_wdata;
  logic              int_gnt;
  logic [DATA_W-1:0] int_rdata;
  logic              int_rvalid;
  logic              rf_en;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;
  logic              busy;
  logic              spi_overrun;
  logic              ro_viol;
  logic              flag_clr;

  modport slave (
    input  spi_req, spi_is_write, spi_addr, spi_wdata,
    input  int_req, int_we, int_addr, int_wdata,
    input  rf_rdata, flag_clr,
    output spi_rdata, spi_rvalid, int_gnt, int_rdata, int_rvalid,
    output rf_en, rf_we, rf_addr, rf_wdata, busy, spi_overrun, ro_viol
  );

  modport master (
    output spi_req, spi_is_write, spi_addr, spi_wdata,
    output int_req, int_we, int_addr, int_wdata,
    output rf_rdata, flag_clr,
    input  spi_rdata, spi_rvalid, int_gnt, int_rdata, int_rvalid,
    input  rf_en, rf_we, rf_addr, rf_wdata, busy, spi_overrun, ro_viol
  );
endinterface

// File: rtl/reg_port_arbiter_spi_req_capture.sv
// Single-entry pending slot for SPI accesses with sticky overrun detection.
module spi_req_capture
  import reg_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  acc_t req_acc,
  input  logic take,
  input  logic flag_clr,
  output acc_t pend,
  output logic pend_v,
  output logic overrun
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend    <= '0;
      pend_v  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (flag_clr) overrun <= 1'b0;
      if (req) begin
        pend   <= req_acc;
        pend_v <= 1'b1;
        if (pend_v && !take) overrun <= 1'b1;
      end else if (take) begin
        pend_v <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_port_arbiter.sv
// Two-requester arbiter for the single-port config register file (spi_clk domain).
// Define ARB_RR_EN for round-robin arbitration; default is fixed SPI priority.
module reg_port_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W  = ARB_ADDR_W,
  parameter int unsigned       DATA_W  = ARB_DATA_W,
  parameter int unsigned       RD_LAT  = 1,
  parameter logic [ADDR_W-1:0] RO_BASE = RO_BASE_DEF
) (
  input  logic                spi_clk,
  input  logic                rst,
  reg_port_arbiter_if.slave   bus
);

  if (ADDR_W != ARB_ADDR_W || DATA_W != ARB_DATA_W) begin : g_width_chk
    $error("reg_port_arbiter: ADDR_W/DATA_W must match reg_arb_pkg acc_t");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_lat_chk
    $error("reg_port_arbiter: RD_LAT must be 1..3");
  end
`ifdef ARB_RR_EN
  if (2 * (RD_LAT + 2) > 8) begin : g_rr_chk
    $error("reg_port_arbiter: round-robin SPI service bound exceeds byte period");
  end
`endif

  state_e            state;
  owner_e            owner;
  logic              issue_we;
  logic [1:0]        cnt;
  acc_t              pend, spi_acc, int_acc, sel;
  logic              pend_v, overrun;
  logic              take_spi, take_int, ro_hit;
  logic              rf_en_q, rf_we_q, spi_rvalid_q, int_rvalid_q, ro_viol_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_wdata_q, spi_rdata_q, int_rdata_q;
`ifdef ARB_RR_EN
  owner_e            last_owner;
`endif

  assign spi_acc = {bus.spi_is_write, bus.spi_addr, bus.spi_wdata};
  assign int_acc = {bus.int_we, bus.int_addr, bus.int_wdata};

  // The slot is released on the cycle the FSM latches it into rf_*, so a strobe
  // landing in that same cycle refills it without counting as an overrun.
  spi_req_capture u_capture (
    .clk      (spi_clk),
    .rst      (rst),
    .req      (bus.spi_req),
    .req_acc  (spi_acc),
    .take     (take_spi),
    .flag_clr (bus.flag_clr),
    .pend     (pend),
    .pend_v   (pend_v),
    .overrun  (overrun)
  );

  always_comb begin
    take_spi = 1'b0;
    take_int = 1'b0;
    if (state == IDLE) begin
`ifdef ARB_RR_EN
      if (pend_v && (!bus.int_req || last_owner == OWN_INT)) take_spi = 1'b1;
      else if (bus.int_req)                                   take_int = 1'b1;
`else
      if (pend_v)           take_spi = 1'b1;
      else if (bus.int_req) take_int = 1'b1;
`endif
    end
    sel    = take_spi ? pend : int_acc;
    ro_hit = sel.we && (sel.addr >= RO_BASE);
  end

  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= OWN_SPI;
      issue_we     <= 1'b0;
      cnt          <= '0;
      rf_en_q      <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_wdata_q   <= '0;
      spi_rdata_q  <= '0;
      spi_rvalid_q <= 1'b0;
      int_rdata_q  <= '0;
      int_rvalid_q <= 1'b0;
      ro_viol_q    <= 1'b0;
`ifdef ARB_RR_EN
      last_owner   <= OWN_INT;
`endif
    end else begin
      rf_en_q      <= 1'b0;
      spi_rvalid_q <= 1'b0;
      int_rvalid_q <= 1'b0;
      if (bus.flag_clr) ro_viol_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take_spi || take_int) begin
            state      <= ISSUE;
            owner      <= take_spi ? OWN_SPI : OWN_INT;
            issue_we   <= sel.we;
            rf_en_q    <= 1'b1;
            rf_we_q    <= sel.we && !ro_hit;
            rf_addr_q  <= sel.addr;
            rf_wdata_q <= sel.wdata;
            if (ro_hit) ro_viol_q <= 1'b1;
          end
        end
        ISSUE: begin
`ifdef ARB_RR_EN
          last_owner <= owner;
`endif
          if (issue_we) begin
            state <= IDLE;
          end else begin
            state <= WAIT_RD;
            cnt   <= 2'(RD_LAT - 1);
          end
        end
        WAIT_RD: begin
          if (cnt == 2'd0) begin
            state <= IDLE;
            if (owner == OWN_SPI) begin
              spi_rdata_q  <= bus.rf_rdata;
              spi_rvalid_q <= 1'b1;
            end else begin
              int_rdata_q  <= bus.rf_rdata;
              int_rvalid_q <= 1'b1;
            end
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rf_en       = rf_en_q;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_addr     = rf_addr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.spi_rdata   = spi_rdata_q;
  assign bus.spi_rvalid  = spi_rvalid_q;
  assign bus.int_rdata   = int_rdata_q;
  assign bus.int_rvalid  = int_rvalid_q;
  assign bus.int_gnt     = take_int;
  assign bus.busy        = (state != IDLE) || pend_v;
  assign bus.spi_overrun = overrun;
  assign bus.ro_viol     = ro_viol_q;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Self-checking bench for reg_port_arbiter: directed timing cases plus a randomized
// two-requester run checked against a register-file content model.
module tb_reg_port_arbiter;
  import reg_arb_pkg::*;

  localparam int unsigned RD_LAT = 2;

  logic spi_clk = 1'b0;
  logic rst;
  always #5 spi_clk = ~spi_clk;

  reg_port_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bus ();

  reg_port_arbiter #(
    .ADDR_W (7),
    .DATA_W (8),
    .RD_LAT (RD_LAT),
    .RO_BASE(7'h60)
  ) dut (
    .spi_clk(spi_clk),
    .rst    (rst),
    .bus    (bus)
  );

  function automatic logic [7:0] model_init(input logic [6:0] a);
    return {1'b0, a} ^ 8'h5A;
  endfunction

  // register file: resets to model_init contents, read data valid RD_LAT cycles after rf_en
  logic [7:0]        mem [128];
  logic [RD_LAT-1:0] pv;
  logic [6:0]        pa [RD_LAT];
  logic [7:0]        junk;
  always @(posedge spi_clk) begin
    junk <= 8'($urandom);
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= model_init(7'(i));
      pv <= '0;
    end else begin
      for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
      pv[0] <= bus.rf_en && !bus.rf_we;
      pa[0] <= bus.rf_addr;
      if (bus.rf_en && bus.rf_we) mem[bus.rf_addr] <= bus.rf_wdata;
    end
  end
  assign bus.rf_rdata = pv[RD_LAT-1] ? mem[pa[RD_LAT-1]] : junk;

  typedef struct packed { logic we; logic [6:0] addr; } rf_ev_t;
  rf_ev_t     rf_log[$];
  logic [7:0] spi_rv_log[$];
  logic [7:0] int_rv_log[$];
  always @(negedge spi_clk) begin
    if (!rst) begin
      if (bus.rf_en)      rf_log.push_back({bus.rf_we, bus.rf_addr});
      if (bus.spi_rvalid) spi_rv_log.push_back(bus.spi_rdata);
      if (bus.int_rvalid) int_rv_log.push_back(bus.int_rdata);
    end
  end

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge spi_clk);
      #1;
    end
  endtask

  task automatic spi_pulse(input logic we, input logic [6:0] a, input logic [7:0] d);
    bus.spi_req      = 1'b1;
    bus.spi_is_write = we;
    bus.spi_addr     = a;
    bus.spi_wdata    = d;
    step(1);
    bus.spi_req      = 1'b0;
  endtask

  task automatic int_issue(input logic we, input logic [6:0] a, input logic [7:0] d,
                           output bit ok);
    bus.int_req   = 1'b1;
    bus.int_we    = we;
    bus.int_addr  = a;
    bus.int_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge spi_clk);
      if (bus.int_gnt) ok = 1'b1;
      @(posedge spi_clk);
      #1;
    end
    bus.int_req = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.rf_en, bus.rf_we, bus.rf_addr, bus.rf_wdata, bus.spi_rvalid,
                bus.spi_rdata, bus.int_rvalid, bus.int_rdata, bus.int_gnt, bus.busy,
                bus.spi_overrun, bus.ro_viol});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [7:0]  ref_spi [64];
  logic [7:0]  ref_int [32];
  logic [7:0]  exp_spi[$];
  logic [7:0]  exp_int[$];
  bit          spi_ro, int_ro;
  int unsigned int_to;

  initial begin
    bit          ok;
    int unsigned n0, n1, n2, base;
    logic [6:0]  a;

    bus.spi_req = 0; bus.spi_is_write = 0; bus.spi_addr = '0; bus.spi_wdata = '0;
    bus.int_req = 0; bus.int_we = 0; bus.int_addr = '0; bus.int_wdata = '0;
    bus.flag_clr = 0;
    rst = 1'b1;
    step(3);
    check("reset_outputs", all_outs(), 64'(0));
    rst = 1'b0;
    step(2);

    // SPI write
    spi_pulse(1'b1, 7'h05, 8'hA5);
    check("wr_busy_pending", 64'(bus.busy), 64'(1));
    step(1);
    check("wr_rf_en", 64'(bus.rf_en), 64'(1));
    check("wr_rf_we", 64'(bus.rf_we), 64'(1));
    check("wr_rf_addr", 64'(bus.rf_addr), 64'(7'h05));
    check("wr_rf_wdata", 64'(bus.rf_wdata), 64'(8'hA5));
    n0 = spi_rv_log.size() + int_rv_log.size();
    step(4);
    check("wr_no_rvalid", 64'(spi_rv_log.size() + int_rv_log.size()), 64'(n0));

    // SPI read of 3C, valid RD_LAT+1 cycles after ISSUE entry
    spi_pulse(1'b1, 7'h06, 8'h3C);
    step(4);
    n1 = int_rv_log.size();
    spi_pulse(1'b0, 7'h06, 8'h00);
    step(3);
    check("rd_rvalid_early", 64'(bus.spi_rvalid), 64'(0));
    step(1);
    check("rd_rvalid", 64'(bus.spi_rvalid), 64'(1));
    check("rd_rdata", 64'(bus.spi_rdata), 64'(8'h3C));
    check("rd_int_rvalid", 64'(bus.int_rvalid), 64'(0));
    step(1);
    check("rd_rvalid_pulse", 64'(bus.spi_rvalid), 64'(0));
    check("rd_int_quiet", 64'(int_rv_log.size()), 64'(n1));

    // write to read-only region
    step(2);
    spi_pulse(1'b1, 7'h62, 8'h77);
    step(1);
    check("ro_rf_en", 64'(bus.rf_en), 64'(1));
    check("ro_rf_we", 64'(bus.rf_we), 64'(0));
    check("ro_viol_set", 64'(bus.ro_viol), 64'(1));
    step(3);
    bus.flag_clr = 1'b1;
    step(1);
    bus.flag_clr = 1'b0;
    check("ro_viol_clr", 64'(bus.ro_viol), 64'(0));

    // contention: internal read in flight when SPI read arrives
    int_issue(1'b0, 7'h10, 8'h00, ok);
    check("cont_int_gnt", 64'(ok), 64'(1));
    step(1);
    spi_pulse(1'b0, 7'h61, 8'h00);
    step(1);
    check("cont_int_rvalid", 64'(bus.int_rvalid), 64'(1));
    check("cont_int_rdata", 64'(bus.int_rdata), 64'(model_init(7'h10)));
    check("cont_spi_wait", 64'(bus.rf_en), 64'(0));
    step(1);
    check("cont_spi_issue", 64'({bus.rf_en, bus.rf_we, bus.rf_addr}), 64'({2'b10, 7'h61}));
    step(3);
    check("cont_spi_rvalid", 64'(bus.spi_rvalid), 64'(1));
    check("cont_spi_rdata", 64'(bus.spi_rdata), 64'(model_init(7'h61)));
    check("cont_no_overrun", 64'(bus.spi_overrun), 64'(0));

    // overrun: two strobes back to back behind an internal read
    step(2);
    base = rf_log.size();
    int_issue(1'b0, 7'h11, 8'h00, ok);
    step(1);
    spi_pulse(1'b0, 7'h20, 8'h00);
    spi_pulse(1'b0, 7'h21, 8'h00);
    check("ovr_set", 64'(bus.spi_overrun), 64'(1));
    step(1);
    check("ovr_second_issued", 64'({bus.rf_en, bus.rf_addr}), 64'({1'b1, 7'h21}));
    step(3);
    check("ovr_rdata", 64'({bus.spi_rvalid, bus.spi_rdata}), 64'({1'b1, model_init(7'h21)}));
    step(4);
    check("ovr_access_count", 64'(rf_log.size() - base), 64'(2));
    bus.flag_clr = 1'b1;
    step(1);
    bus.flag_clr = 1'b0;
    check("ovr_clr", 64'(bus.spi_overrun), 64'(0));

    // reset during WAIT_RD aborts the read
    spi_pulse(1'b1, 7'h63, 8'h01);
    step(3);
    spi_pulse(1'b0, 7'h40, 8'h00);
    step(2);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", all_outs(), 64'(0));
    step(2);
    rst = 1'b0;
    n0 = spi_rv_log.size();
    n1 = int_rv_log.size();
    n2 = rf_log.size();
    step(6);
    check("rst_no_rvalid", 64'({spi_rv_log.size() - n0, int_rv_log.size() - n1}), 64'(0));
    check("rst_no_access", 64'(rf_log.size() - n2), 64'(0));

    // arbitration with both requesters continuously pending
    base = rf_log.size();
    bus.spi_req = 1'b1; bus.spi_is_write = 1'b0; bus.spi_addr = 7'h31;
    step(1);
    bus.int_req = 1'b1; bus.int_we = 1'b0; bus.int_addr = 7'h30;
    step(27);
    bus.spi_req = 1'b0;
    bus.int_req = 1'b0;
    step(8);
    check("arb_count", 64'(rf_log.size() - base >= 5), 64'(1));
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      check("arb_rr_order", 64'(rf_log[base + k].addr), 64'((k % 2 == 0) ? 7'h31 : 7'h30));
`else
      check("arb_fixed_order", 64'(rf_log[base + k].addr), 64'(7'h31));
`endif
    end

    // randomized run: SPI one access per 8-cycle byte, internal back-to-back with gaps
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    for (int i = 0; i < 64; i++) ref_spi[i] = model_init(7'(i));
    for (int i = 0; i < 32; i++) ref_int[i] = model_init(7'(i + 64));
    spi_ro = 0; int_ro = 0; int_to = 0;
    n0 = spi_rv_log.size();
    n1 = int_rv_log.size();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic       we;
          logic [6:0] sa;
          logic [7:0] d;
          we = 1'($urandom);
          sa = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(0, 63));
          d  = 8'($urandom);
          if (we) begin
            if (sa >= 7'h60) spi_ro = 1;
            else ref_spi[sa[5:0]] = d;
          end else begin
            exp_spi.push_back(sa >= 7'h60 ? model_init(sa) : ref_spi[sa[5:0]]);
          end
          spi_pulse(we, sa, d);
          step(7);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          logic       we;
          logic [6:0] ia;
          logic [7:0] d;
          bit         g;
          step($urandom_range(0, 3));
          we = 1'($urandom);
          ia = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(64, 95));
          d  = 8'($urandom);
          if (we) begin
            if (ia >= 7'h60) int_ro = 1;
            else ref_int[ia[4:0]] = d;
          end else begin
            exp_int.push_back(ia >= 7'h60 ? model_init(ia) : ref_int[ia[4:0]]);
          end
          int_issue(we, ia, d, g);
          if (!g) int_to++;
        end
      end
    join
    step(12);
    check("rand_int_grant_timeouts", 64'(int_to), 64'(0));
    check("rand_spi_rd_count", 64'(spi_rv_log.size() - n0), 64'(exp_spi.size()));
    for (int i = 0; i < exp_spi.size() && n0 + i < spi_rv_log.size(); i++)
      check("rand_spi_rdata", 64'(spi_rv_log[n0 + i]), 64'(exp_spi[i]));
    check("rand_int_rd_count", 64'(int_rv_log.size() - n1), 64'(exp_int.size()));
    for (int i = 0; i < exp_int.size() && n1 + i < int_rv_log.size(); i++)
      check("rand_int_rdata", 64'(int_rv_log[n1 + i]), 64'(exp_int[i]));
    check("rand_no_overrun", 64'(bus.spi_overrun), 64'(0));
    check("rand_ro_viol", 64'(bus.ro_viol), 64'(spi_ro || int_ro));
    a = 7'h7F;
    check("rand_ro_region_kept", 64'(mem[a]), 64'(model_init(a)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
